// File: rtl/x25519_byte_host.sv
// Byte-stream host for the Curve25519 scalar_multiplication core: RFC 7748 decode, launch, encode.
// Optional macro X25519_CLAMP_EN: when defined, the scalar is clamped during DECODE.
module x25519_byte_host #(
  parameter int CORE_RST_CYCLES = 2,
  parameter int CNT_W           = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [7:0]       out_data,
  output logic             out_last,
  output logic             busy,
  output logic [254:0]     core_k,
  output logic [254:0]     core_x_p,
  output logic             core_rst,
  input  logic [254:0]     core_x_q,
  input  logic             core_done,
  output logic [CNT_W-1:0] cycles
);

  localparam logic [254:0] P = {{250{1'b1}}, 5'b01101};
  localparam int LW = (CORE_RST_CYCLES > 1) ? $clog2(CORE_RST_CYCLES) : 1;

  typedef enum logic [2:0] {LOAD_K, LOAD_U, DECODE, LAUNCH, WAIT, SEND} state_t;

  state_t        state;
  logic [511:0]  req;
  logic [4:0]    idx;
  logic [247:0]  xq;
  logic [LW-1:0] launch_cnt;
  logic          first_wait;

  // Request bytes shift in from the top, so after 64 bytes k is req[255:0] and u is req[511:256].
  logic [254:0] u_m;
  logic [254:0] x_p_dec;
  logic [254:0] k_dec;

  always_comb begin
    u_m     = req[510:256];
    x_p_dec = (u_m >= P) ? (u_m - P) : u_m;
`ifdef X25519_CLAMP_EN
    k_dec   = (req[254:0] & ~255'd7) | {1'b1, 254'd0};
`else
    k_dec   = req[254:0];
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= LOAD_K;
      req        <= '0;
      idx        <= '0;
      xq         <= '0;
      launch_cnt <= '0;
      first_wait <= 1'b0;
      in_ready   <= 1'b0;
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_last   <= 1'b0;
      busy       <= 1'b0;
      core_rst   <= 1'b1;
      core_k     <= '0;
      core_x_p   <= '0;
      cycles     <= '0;
    end else begin
      case (state)
        LOAD_K, LOAD_U: begin
          in_ready <= 1'b1;
          if (in_valid && in_ready) begin
            req  <= {in_data, req[511:8]};
            busy <= 1'b1;
            idx  <= idx + 5'd1;
            if (idx == 5'd31) begin
              if (state == LOAD_K) begin
                state <= LOAD_U;
              end else begin
                state    <= DECODE;
                in_ready <= 1'b0;
              end
            end
          end
        end
        DECODE: begin
          core_k     <= k_dec;
          core_x_p   <= x_p_dec;
          cycles     <= '0;
          launch_cnt <= '0;
          state      <= LAUNCH;
        end
        LAUNCH: begin
          if (launch_cnt == LW'(CORE_RST_CYCLES - 1)) begin
            core_rst   <= 1'b0;
            first_wait <= 1'b1;
            state      <= WAIT;
          end else begin
            launch_cnt <= launch_cnt + LW'(1);
          end
        end
        WAIT: begin
          first_wait <= 1'b0;
          // A done left over from the previous run can still be high on the first cycle.
          if (core_done && !first_wait) begin
            xq        <= {1'b0, core_x_q[254:8]};
            out_data  <= core_x_q[7:0];
            out_valid <= 1'b1;
            out_last  <= 1'b0;
            idx       <= '0;
            core_rst  <= 1'b1;
            state     <= SEND;
          end else if (cycles != {CNT_W{1'b1}}) begin
            cycles <= cycles + CNT_W'(1);
          end
        end
        SEND: begin
          if (out_ready) begin
            if (idx == 5'd31) begin
              out_valid <= 1'b0;
              out_last  <= 1'b0;
              busy      <= 1'b0;
              in_ready  <= 1'b1;
              idx       <= '0;
              state     <= LOAD_K;
            end else begin
              out_data <= xq[7:0];
              xq       <= {8'h00, xq[247:8]};
              out_last <= (idx == 5'd30);
              idx      <= idx + 5'd1;
            end
          end
        end
        default: state <= LOAD_K;
      endcase
    end
  end

endmodule

// File: tb/tb_x25519_byte_host.sv
// Directed vector bench for x25519_byte_host with a behavioural latency model of the ladder core.
module tb_x25519_byte_host;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [7:0]   in_data;
  logic         out_valid;
  logic         out_ready;
  logic [7:0]   out_data;
  logic         out_last;
  logic         busy;
  logic [254:0] core_k;
  logic [254:0] core_x_p;
  logic         core_rst;
  logic [254:0] core_x_q;
  logic         core_done;
  logic [31:0]  cycles;

  always #5 clk = ~clk;

  x25519_byte_host dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
    .busy(busy), .core_k(core_k), .core_x_p(core_x_p), .core_rst(core_rst),
    .core_x_q(core_x_q), .core_done(core_done), .cycles(cycles)
  );

  localparam logic [254:0] P = {{250{1'b1}}, 5'b01101};

  // Core model: done rises after model_lat clocks with core_rst low, cleared while in reset.
  logic [254:0] model_xq;
  int           model_lat;
  int           mcnt;
  assign core_x_q = model_xq;

  always @(posedge clk) begin
    if (core_rst) begin
      mcnt      <= 0;
      core_done <= 1'b0;
    end else begin
      mcnt <= mcnt + 1;
      if (mcnt + 1 >= model_lat) core_done <= 1'b1;
    end
  end

  typedef struct {
    logic [255:0] k;
    logic [255:0] u;
    logic [254:0] exp_k;
    logic [254:0] exp_xp;
    logic [254:0] xq;
    logic [255:0] exp_out;
    int           lat;
    bit           stall;
  } vec_t;

  vec_t vecs[5];
  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic send_req(input logic [255:0] k, input logic [255:0] u, input bit gaps, input int nb);
    logic [511:0] req;
    int i;
    int guard;
    req   = {u, k};
    i     = 0;
    guard = 0;
    while (i < nb && guard < 5000) begin
      @(negedge clk);
      guard++;
      if (gaps && $urandom_range(0, 2) == 0) begin
        in_valid = 1'b0;
      end else begin
        in_valid = 1'b1;
        in_data  = req[8*i +: 8];
        if (in_ready) i++;
      end
    end
    if (i < nb) chk("send_timeout", 256'(i), 256'(nb));
  endtask

  task automatic recv(input int nbytes, input bit stall, input logic [255:0] exp_out, input string tag);
    int idx;
    int guard;
    bit rdy;
    bit held;
    logic [7:0] prev;
    idx   = 0;
    guard = 0;
    held  = 1'b0;
    prev  = '0;
    while (idx < nbytes && guard < 3000) begin
      @(negedge clk);
      guard++;
      if (out_valid) begin
        if (held) chk($sformatf("%s_stall_stable%0d", tag, idx), 256'(out_data), 256'(prev));
        rdy       = stall ? (guard % 2 == 1) : 1'b1;
        out_ready = rdy;
        if (rdy) begin
          chk($sformatf("%s_byte%0d", tag, idx), 256'(out_data), 256'(exp_out[8*idx +: 8]));
          chk($sformatf("%s_last%0d", tag, idx), 256'(out_last), 256'(idx == 31));
          idx++;
          held = 1'b0;
        end else begin
          held = 1'b1;
          prev = out_data;
        end
      end
    end
    if (idx < nbytes) chk($sformatf("%s_recv_timeout", tag), 256'(idx), 256'(nbytes));
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_in_ready"}, 256'(in_ready), 256'(0));
    chk({tag, "_out_valid"}, 256'(out_valid), 256'(0));
    chk({tag, "_out_data"}, 256'(out_data), 256'(0));
    chk({tag, "_out_last"}, 256'(out_last), 256'(0));
    chk({tag, "_busy"}, 256'(busy), 256'(0));
    chk({tag, "_core_rst"}, 256'(core_rst), 256'(1));
    chk({tag, "_core_k"}, 256'(core_k), 256'(0));
    chk({tag, "_core_x_p"}, 256'(core_x_p), 256'(0));
    chk({tag, "_cycles"}, 256'(cycles), 256'(0));
  endtask

  // Sends a request, checks the launch window and decoded operands, then drains the response.
  task automatic run_vec(input int n, input vec_t v);
    int hi;
    model_xq  = v.xq;
    model_lat = v.lat;
    send_req(v.k, v.u, v.stall, 64);
    @(negedge clk);
    in_valid = 1'b0;
    hi = 0;
    while (core_rst && hi < 50) begin
      hi++;
      @(negedge clk);
    end
    // One DECODE cycle followed by two LAUNCH cycles with core_rst high.
    chk($sformatf("v%0d_launch_len", n), 256'(hi), 256'(3));
    chk($sformatf("v%0d_core_k", n), 256'(core_k), 256'(v.exp_k));
    chk($sformatf("v%0d_core_x_p", n), 256'(core_x_p), 256'(v.exp_xp));
    chk($sformatf("v%0d_in_ready_low", n), 256'(in_ready), 256'(0));
    chk($sformatf("v%0d_busy", n), 256'(busy), 256'(1));
    recv(32, v.stall, v.exp_out, $sformatf("v%0d", n));
    @(negedge clk);
    out_ready = 1'b0;
    chk($sformatf("v%0d_done_valid", n), 256'(out_valid), 256'(0));
    chk($sformatf("v%0d_done_busy", n), 256'(busy), 256'(0));
    chk($sformatf("v%0d_done_in_ready", n), 256'(in_ready), 256'(1));
    chk($sformatf("v%0d_cycles", n), 256'(cycles), 256'(v.lat));
    $display("vector %0d: k=%h x_p=%h cycles=%0d", n, core_k, core_x_p, cycles);
  endtask

  task automatic watch_silent(input string tag, input int n);
    int seen;
    seen = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    chk(tag, 256'(seen), 256'(0));
  endtask

  initial begin
    vecs[0].k = '1; vecs[0].u = '1;
`ifdef X25519_CLAMP_EN
    vecs[0].exp_k = {{252{1'b1}}, 3'b000};
`else
    vecs[0].exp_k = {255{1'b1}};
`endif
    vecs[0].exp_xp = 255'd18; vecs[0].xq = 255'h0102; vecs[0].exp_out = 256'h0102;
    vecs[0].lat = 100; vecs[0].stall = 1'b0;

    vecs[1].k = 256'd5; vecs[1].u = {1'b0, P};
`ifdef X25519_CLAMP_EN
    vecs[1].exp_k = {1'b1, 254'd0};
`else
    vecs[1].exp_k = 255'd5;
`endif
    vecs[1].exp_xp = 255'd0; vecs[1].xq = {255{1'b1}}; vecs[1].exp_out = {1'b0, {255{1'b1}}};
    vecs[1].lat = 3; vecs[1].stall = 1'b0;

    vecs[2].k = {1'b1, 251'd0, 4'hF}; vecs[2].u = {1'b0, {250{1'b1}}, 5'b01100};
`ifdef X25519_CLAMP_EN
    vecs[2].exp_k = {1'b1, 250'd0, 4'h8};
`else
    vecs[2].exp_k = 255'hF;
`endif
    vecs[2].exp_xp = {{250{1'b1}}, 5'b01100}; vecs[2].xq = 255'h55AA; vecs[2].exp_out = 256'h55AA;
    vecs[2].lat = 1; vecs[2].stall = 1'b1;

    vecs[3].k = 256'h40; vecs[3].u = {1'b1, 255'd7};
`ifdef X25519_CLAMP_EN
    vecs[3].exp_k = {1'b1, 254'd64};
`else
    vecs[3].exp_k = 255'd64;
`endif
    vecs[3].exp_xp = 255'd7; vecs[3].xq = {7'h7F, 240'd0, 8'hAB}; vecs[3].exp_out = {8'h7F, 240'd0, 8'hAB};
    vecs[3].lat = 100; vecs[3].stall = 1'b1;

    vecs[4] = vecs[0];
    vecs[4].stall = 1'b1;

    rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    model_xq = '0; model_lat = 100;
    repeat (3) @(negedge clk);
    check_reset_vals("reset");
    rst = 1'b0;
    @(negedge clk);
    chk("reset_release_in_ready", 256'(in_ready), 256'(1));

    for (int n = 0; n < 5; n++) run_vec(n, vecs[n]);

    // Reset while the core is running.
    model_xq = vecs[0].xq; model_lat = 100;
    send_req(vecs[0].k, vecs[0].u, 1'b0, 64);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (10) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_reset_vals("rst_wait");
    rst = 1'b0;
    @(negedge clk);
    chk("rst_wait_in_ready", 256'(in_ready), 256'(1));
    watch_silent("rst_wait_no_out", 150);
    $display("reset during WAIT applied");

    // Reset after ten response bytes, with the host still willing to accept.
    model_xq = vecs[3].xq; model_lat = 20;
    send_req(vecs[3].k, vecs[3].u, 1'b0, 64);
    @(negedge clk);
    in_valid = 1'b0;
    recv(10, 1'b0, vecs[3].exp_out, "partial");
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_reset_vals("rst_send");
    rst = 1'b0;
    watch_silent("rst_send_no_out", 50);
    out_ready = 1'b0;
    $display("reset during SEND applied");

    // A partial request cut by reset must not leak into the next one.
    send_req(vecs[2].k, vecs[2].u, 1'b0, 20);
    @(negedge clk);
    in_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    check_reset_vals("rst_load");
    rst = 1'b0;
    @(negedge clk);
    run_vec(5, vecs[1]);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
